// File: rtl/text_mode_renderer.sv
// rtl/text_mode_renderer.sv - 100x37 text-cell renderer, 4-cycle fixed pipeline to 12-bit RGB.
// Optional blinking cursor cell enabled by defining TEXT_CURSOR_EN.
`timescale 1ns/1ps

module text_mode_renderer #(
    parameter int          COLS       = 100,
    parameter int          ROWS       = 37,
    parameter logic [11:0] BORDER_RGB = 12'h000
) (
    input  logic        clk40,
    input  logic        reset,
    input  logic [9:0]  hPos,
    input  logic [9:0]  vPos,
    input  logic        videoActive,
    input  logic        hsyncIn,
    input  logic        vsyncIn,
`ifdef TEXT_CURSOR_EN
    input  logic [6:0]  cursorCol,
    input  logic [5:0]  cursorRow,
`endif
    output logic [11:0] charAddr,
    input  logic [15:0] charData,
    output logic [11:0] fontAddr,
    input  logic [7:0]  fontData,
    output logic [11:0] rgb,
    output logic        hsyncOut,
    output logic        vsyncOut,
    output logic        activeOut
);

    localparam logic [11:0] COLS_W     = 12'(COLS);
    localparam logic [9:0]  TEXT_LINES = 10'(ROWS * 16);

    typedef struct packed {
        logic [2:0] px;
        logic [3:0] line;
        logic       in_text;
        logic       active;
        logic       hsync;
        logic       vsync;
        logic       cursor;
    } side_t;

    side_t       s1, s2, s3, s4;
    logic [7:0]  attr3, attr4;
    logic        in_text;
    logic [11:0] cell_addr;
    logic        cursor_hit;

    function automatic logic [11:0] pal(input logic [3:0] i);
        logic [3:0] hi, lo;
        hi = i[3] ? 4'hF : 4'hA;
        lo = i[3] ? 4'h5 : 4'h0;
        return {i[2] ? hi : lo, i[1] ? hi : lo, i[0] ? hi : lo};
    endfunction

    assign in_text   = videoActive && (vPos < TEXT_LINES);
    assign cell_addr = ({6'd0, vPos[9:4]} * COLS_W) + {5'd0, hPos[9:3]};

`ifdef TEXT_CURSOR_EN
    logic [5:0] frame_count;
    logic       vsync_prev;

    always_ff @(posedge clk40) begin
        if (reset) begin
            frame_count <= 6'd0;
            vsync_prev  <= 1'b0;
        end else begin
            vsync_prev <= vsyncIn;
            if (vsyncIn && !vsync_prev)
                frame_count <= frame_count + 6'd1;
        end
    end

    // Blink phase is the counter MSB: 32 frames on, 32 frames off.
    assign cursor_hit = in_text && frame_count[5] &&
                        (hPos[9:3] == cursorCol) && (vPos[9:4] == cursorRow);
`else
    assign cursor_hit = 1'b0;
`endif

    // Edge n: cell address and sideband capture.
    always_ff @(posedge clk40) begin
        if (reset) begin
            charAddr <= 12'd0;
            s1       <= '0;
        end else begin
            charAddr   <= in_text ? cell_addr : 12'd0;
            s1.px      <= hPos[2:0];
            s1.line    <= vPos[3:0];
            s1.in_text <= in_text;
            s1.active  <= videoActive;
            s1.hsync   <= hsyncIn;
            s1.vsync   <= vsyncIn;
            s1.cursor  <= cursor_hit;
        end
    end

    // Edge n+1: character RAM read in flight.
    always_ff @(posedge clk40) begin
        if (reset) s2 <= '0;
        else       s2 <= s1;
    end

    // Edge n+2: glyph row address and attribute capture.
    always_ff @(posedge clk40) begin
        if (reset) begin
            fontAddr <= 12'd0;
            attr3    <= 8'd0;
            s3       <= '0;
        end else begin
            fontAddr <= s2.in_text ? {charData[7:0], s2.line} : 12'd0;
            attr3    <= s2.in_text ? charData[15:8] : 8'd0;
            s3       <= s2;
        end
    end

    // Edge n+3: font ROM read in flight.
    always_ff @(posedge clk40) begin
        if (reset) begin
            attr4 <= 8'd0;
            s4    <= '0;
        end else begin
            attr4 <= attr3;
            s4    <= s3;
        end
    end

    logic       pixel;
    logic [3:0] fg_idx, bg_idx;

    always_comb begin
        pixel  = fontData[3'd7 - s4.px];
        fg_idx = s4.cursor ? attr4[7:4] : attr4[3:0];
        bg_idx = s4.cursor ? attr4[3:0] : attr4[7:4];
    end

    // Edge n+4: colour lookup and aligned syncs.
    always_ff @(posedge clk40) begin
        if (reset) begin
            rgb       <= 12'd0;
            hsyncOut  <= 1'b0;
            vsyncOut  <= 1'b0;
            activeOut <= 1'b0;
        end else begin
            rgb       <= s4.in_text ? pal(pixel ? fg_idx : bg_idx) : BORDER_RGB;
            hsyncOut  <= s4.hsync;
            vsyncOut  <= s4.vsync;
            activeOut <= s4.active;
        end
    end

endmodule

// File: tb/tb_text_mode_renderer.sv
// tb/tb_text_mode_renderer.sv - scoreboard bench for text_mode_renderer with RAM/ROM models.
`timescale 1ns/1ps

module tb_text_mode_renderer;

    logic        clk40 = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  hPos = '0, vPos = '0;
    logic        videoActive = 1'b0, hsyncIn = 1'b0, vsyncIn = 1'b0;
    logic [11:0] charAddr, fontAddr, rgb;
    logic [15:0] charData;
    logic [7:0]  fontData;
    logic        hsyncOut, vsyncOut, activeOut;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cursor_col = 7'd5;
    logic [5:0]  cursor_row = 6'd2;
`endif

    always #5 clk40 = ~clk40;

    text_mode_renderer dut (
        .clk40(clk40), .reset(reset),
        .hPos(hPos), .vPos(vPos), .videoActive(videoActive),
        .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
`ifdef TEXT_CURSOR_EN
        .cursorCol(cursor_col), .cursorRow(cursor_row),
`endif
        .charAddr(charAddr), .charData(charData),
        .fontAddr(fontAddr), .fontData(fontData),
        .rgb(rgb), .hsyncOut(hsyncOut), .vsyncOut(vsyncOut), .activeOut(activeOut)
    );

    logic [15:0] ram [0:4095];
    logic [7:0]  rom [0:4095];

    always @(posedge clk40) begin
        charData <= ram[charAddr];
        fontData <= rom[fontAddr];
    end

    typedef struct {
        logic [11:0] ch;
        logic [11:0] fa;
        logic [11:0] rgb;
        logic        hs, vs, act;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       rst_req = 1'b1;
    logic [5:0] fc = 6'd0;
    logic       vs_prev = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_pal(input logic [3:0] i);
        int r, g, b;
        r = int'(i[2]) * 10 + int'(i[3]) * 5;
        g = int'(i[1]) * 10 + int'(i[3]) * 5;
        b = int'(i[0]) * 10 + int'(i[3]) * 5;
        return {4'(r), 4'(g), 4'(b)};
    endfunction

    task automatic step(input logic [9:0] h, input logic [9:0] v,
                        input logic act, input logic hs, input logic vs);
        exp_t       e;
        exp_t       o;
        logic       it, bitv, hit;
        logic [7:0] attr, row;
        logic [3:0] fg, bg;
        int         idx;
        @(negedge clk40);
        if (reset) begin
            check_val("rst_char", 32'(charAddr), 32'd0);
            check_val("rst_font", 32'(fontAddr), 32'd0);
            check_val("rst_rgb", 32'(rgb), 32'd0);
            check_val("rst_sync", {29'd0, hsyncOut, vsyncOut, activeOut}, 32'd0);
        end else begin
            if (sb.size() >= 1) check_val("char_addr", 32'(charAddr), 32'(sb[$].ch));
            if (sb.size() >= 3) check_val("font_addr", 32'(fontAddr), 32'(sb[sb.size()-3].fa));
            if (sb.size() >= 5) begin
                o = sb.pop_front();
                check_val("rgb", 32'(rgb), 32'(o.rgb));
                check_val("sync_act", {29'd0, hsyncOut, vsyncOut, activeOut},
                          {29'd0, o.hs, o.vs, o.act});
            end
        end
        reset       = rst_req;
        hPos        = h;
        vPos        = v;
        videoActive = act;
        hsyncIn     = hs;
        vsyncIn     = vs;
        if (reset) begin
            sb.delete();
            fc      = 6'd0;
            vs_prev = 1'b0;
        end else begin
            it   = act && (v < 10'd592);
            e.ch = it ? 12'(int'(v[9:4]) * 100 + int'(h[9:3])) : 12'd0;
            e.fa = it ? {ram[e.ch][7:0], v[3:0]} : 12'd0;
            attr = ram[e.ch][15:8];
            row  = rom[e.fa];
            idx  = 7 - int'(h[2:0]);
            bitv = row[idx];
`ifdef TEXT_CURSOR_EN
            hit = it && fc[5] && (h[9:3] == 7'd5) && (v[9:4] == 6'd2);
`else
            hit = 1'b0;
`endif
            fg = hit ? attr[7:4] : attr[3:0];
            bg = hit ? attr[3:0] : attr[7:4];
            e.rgb = it ? ref_pal(bitv ? fg : bg) : 12'h000;
            e.hs  = hs;
            e.vs  = vs;
            e.act = act;
            sb.push_back(e);
            if (vs && !vs_prev) fc = fc + 6'd1;
            vs_prev = vs;
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 16'($urandom);
            rom[i] = 8'($urandom);
        end
        ram[0]      = 16'h1F41;
        rom[12'h410] = 8'h80;
        for (int c = 4; c <= 6; c++) ram[200 + c] = {8'h07, 8'(8'h30 + c)};

        rst_req = 1'b1;
        repeat (4) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        rst_req = 1'b0;

        for (int h = 0; h < 16; h++) step(10'(h), 10'd0, 1'b1, 1'b0, 1'b0);

        for (int h = 100; h < 110; h++) step(10'(h), 10'd40, 1'b1, 1'b0, 1'b0);
        rst_req = 1'b1;
        for (int h = 110; h < 113; h++) step(10'(h), 10'd40, 1'b1, 1'b0, 1'b0);
        rst_req = 1'b0;
        for (int h = 113; h < 140; h++) step(10'(h), 10'd40, 1'b1, 1'b0, 1'b0);

        step(10'd799, 10'd591, 1'b1, 1'b0, 1'b0);
        step(10'd798, 10'd591, 1'b1, 1'b0, 1'b0);
        step(10'd0, 10'd591, 1'b1, 1'b0, 1'b0);

        repeat (300) step(10'($urandom_range(799)), 10'($urandom_range(599)), 1'b1, 1'b0, 1'b0);

        for (int v = 592; v < 600; v++)
            repeat (4) step(10'($urandom_range(799)), 10'(v), 1'b1, 1'b0, 1'b0);

        for (int ln = 600; ln < 606; ln++)
            for (int c = 800; c < 1056; c++)
                step(10'd0, 10'd0, 1'b0, (c >= 840) && (c <= 967), (ln >= 601) && (ln <= 604));

        while (!fc[5]) begin
            step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
            step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        end
        for (int v = 32; v < 36; v++)
            for (int h = 32; h < 56; h++) step(10'(h), 10'(v), 1'b1, 1'b0, 1'b0);

        while (fc[5]) begin
            step(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
            step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
        end
        for (int v = 32; v < 36; v++)
            for (int h = 32; h < 56; h++) step(10'(h), 10'(v), 1'b1, 1'b0, 1'b0);

        repeat (8) step(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/text_mode_renderer.md
Name: text_mode_renderer

Overview:
- Downstream of the 800x600 frame timing generator in the clk40 domain; consumes hPos/vPos/videoActive/hsync/vsync and produces a 12-bit RGB pixel stream with realigned syncs.
- Renders 100x37 text cells of 8x16 pixels from an external synchronous character RAM and font ROM; lines 592-599 are blank.

Parameters:
- COLS, 100, text columns per row (800/8)
- ROWS, 37, text rows (lines >= ROWS*16 render as border)
- BORDER_RGB, 12'h000, colour emitted outside text area and during blanking

Ports:
- clk40  in  1  pixel clock, 40 MHz
- reset  in  1  synchronous, active-high reset
- hPos  in  10  horizontal pixel position from the frame timing generator (0 when inactive)
- vPos  in  10  vertical line position from the frame timing generator (0 when inactive)
- videoActive  in  1  high inside the 800x600 visible area
- hsyncIn  in  1  hsync from the frame timing generator, active-high
- vsyncIn  in  1  vsync from the frame timing generator, active-high
- charAddr  out  12  character RAM address, registered
- charData  in  16  character RAM read data {attr[7:0], code[7:0]}; 1-cycle read latency
- fontAddr  out  12  font ROM address {code[7:0], line[3:0]}, registered
- fontData  in  8  font ROM row; bit 7 = leftmost pixel; 1-cycle read latency
- rgb  out  12  {R[3:0], G[3:0], B[3:0]}, registered
- hsyncOut  out  1  hsyncIn delayed to align with rgb
- vsyncOut  out  1  vsyncIn delayed to align with rgb
- activeOut  out  1  videoActive delayed to align with rgb

Behaviour:
- Reset: charAddr, fontAddr, rgb, hsyncOut, vsyncOut and activeOut all 0; every pipeline register cleared. Reset asserted mid-frame flushes the pipeline. Outputs are correct again 4 cycles after reset deasserts.
- Pipeline: inputs are sampled at edge n, and rgb/hsyncOut/vsyncOut/activeOut reflect them after edge n+4. Fixed latency of 4; no stalls, no handshake.
  - Edge n: register charAddr = vPos[9:4]*COLS + hPos[9:3]. Max 36*100+99 = 3699, which fits in 12 bits. Register stage-1 copies of hPos[2:0], vPos[3:0], inText, active and syncs.
  - Edge n+1: RAM captures charAddr. Stage-2 copies of the sideband signals are advanced.
  - Edge n+2: register fontAddr = {charData[7:0], line}. Latch attr = charData[15:8] into stage 3.
  - Edge n+3: ROM captures fontAddr. Sideband and attr are advanced.
  - Edge n+4: pixel = fontData[7 - hPos[2:0]]. rgb = pal(pixel ? attr[3:0] : attr[7:4]). Syncs and active are output.
- inText = videoActive && vPos < ROWS*16. When inText is 0: charAddr is forced to 0, fontAddr is forced to 0, and rgb = BORDER_RGB at the aligned output cycle.
- Palette pal(i), per channel c in {R:bit2, G:bit1, B:bit0}:
  - c set: 4'hF if i[3] else 4'hA
  - c clear: 4'h5 if i[3] else 4'h0
  - Example: i=0 gives 000; i=7 gives AAA; i=8 gives 555; i=15 gives FFF.
- Arithmetic: multiply by the constant COLS using a 12-bit result; no wrap is possible within the 800x600 area.
- Sync delay: hsyncOut/vsyncOut are pure 4-stage delays with no glitch filtering; polarity is preserved (active-high).
- Simultaneous events: reset has priority over pipeline advance on every register.

Optional Feature:
- Macro: TEXT_CURSOR_EN
- With the macro defined:
  - Extra inputs cursorCol[6:0] and cursorRow[5:0].
  - Internal 6-bit frame counter increments on each rising edge of vsyncIn; it resets to 0.
  - When the cell under render matches (cursorCol, cursorRow) and frameCount[5] = 1, fg and bg indices are swapped for that cell. Cell match is computed at edge n and pipelined with the data.
  - Blink period is 64 frames, 50% duty.
- Without the macro: no cursor ports, no frame counter, output identical to the cursor-off case.

Test Plan:
- Reset held 3 cycles mid-line, then released -> all outputs 0 while reset is high; first valid rgb appears 4 cycles after release; no X on any output.
- hPos=0, vPos=0, active; RAM[0]=16'h1F41; ROM[0x410]=8'h80 -> charAddr=0 after edge n; fontAddr=0x410 after edge n+2; rgb=FFF at n+4; next pixel (hPos=1) rgb=00A.
- hPos=799, vPos=591 -> charAddr=36*100+99=3699; fontAddr line field = 4'hF.
- vPos=592..599 with active=1 -> charAddr=0, rgb=BORDER_RGB, activeOut=1 with 4-cycle delay.
- hsyncIn pulse on hPos counts 840..967, vsyncIn pulse on lines 601..604 -> hsyncOut/vsyncOut identical pulses shifted exactly 4 clk40 cycles.
- TEXT_CURSOR_EN, cursor=(5,2), attr=8'h07, 32 vsync edges -> cell (5,2) renders fg=0/bg=7 swapped; after 64 edges it renders normally; other cells are unaffected.
